// File: rtl/mult59_pkg.sv
`timescale 1ns/1ps
// Shared widths, limb-split helper and partial-product types for the 59x59 signed multiplier.
package mult59_pkg;
    localparam int W_IN      = 59;
    localparam int W_OUT     = 118;
    localparam int LIMB      = 17;
    localparam int LATENCY   = 12;
    localparam int NUM_LIMBS = 4;
    localparam int PP_W      = 2 * (LIMB + 1);
    localparam int ACC_W     = W_OUT + 2;
    localparam int TOP_W     = W_IN - (NUM_LIMBS - 1) * LIMB;
    localparam int TREE_LVLS = 4;

    typedef logic signed [PP_W-1:0] pp_t;
    typedef logic        [ACC_W-1:0] acc_t;

    // Lower limbs are unsigned (zero-extended); only the 8-bit top limb carries the sign.
    function automatic logic signed [LIMB:0] limb(input logic [W_IN-1:0] x, input int idx);
        case (idx)
            0:       return {1'b0, x[LIMB-1:0]};
            1:       return {1'b0, x[2*LIMB-1:LIMB]};
            2:       return {1'b0, x[3*LIMB-1:2*LIMB]};
            default: return {{(LIMB+1-TOP_W){x[W_IN-1]}}, x[W_IN-1:3*LIMB]};
        endcase
    endfunction
endpackage

// File: rtl/mult59_limb_mul.sv
`timescale 1ns/1ps
// 18x18 signed multiply, operand register then product register (two stages).
module mult59_limb_mul
    import mult59_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic signed [LIMB:0] a_i,
    input  logic signed [LIMB:0] b_i,
    output pp_t                 p_o
);
    logic signed [LIMB:0] a_q, b_q;
    pp_t                  p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else if (en_i) begin
            a_q <= a_i;
            b_q <= b_i;
            p_q <= pp_t'(a_q) * pp_t'(b_q);
        end
    end

    assign p_o = p_q;
endmodule

// File: rtl/mult59x59_pipe.sv
`timescale 1ns/1ps
// Fully pipelined signed 59x59 -> 118 multiplier. Stages: input reg, 2 limb-multiply,
// 4 adder-tree levels, balancing delay, output reg -- LATENCY enabled edges in total.
module mult59x59_pipe
    import mult59_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W_IN-1:0]  R,
    input  logic [W_IN-1:0]  S,
    output logic [W_OUT-1:0] multout
);
    localparam int NPP = NUM_LIMBS * NUM_LIMBS;
    localparam int DLY = LATENCY - 3 - TREE_LVLS - 1;

    logic [W_IN-1:0]  r_q, s_q;
    pp_t              pp     [NPP];
    acc_t             leaf   [NPP];
    acc_t             node_q [NPP-1];
    logic [W_OUT-1:0] dly_q  [DLY];
    logic [W_OUT-1:0] multout_q;
    logic             unused_guard;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
            s_q <= '0;
        end else if (en) begin
            r_q <= R;
            s_q <= S;
        end
    end

    for (genvar i = 0; i < NUM_LIMBS; i++) begin : g_row
        for (genvar j = 0; j < NUM_LIMBS; j++) begin : g_col
            localparam int K = i * NUM_LIMBS + j;
            mult59_limb_mul u_mul (
                .clk   (clk),
                .rst_n (rst),
                .en_i  (en),
                .a_i   (limb(r_q, i)),
                .b_i   (limb(s_q, j)),
                .p_o   (pp[K])
            );
            // Sign-extend to the accumulator width, then place at weight 2^(17*(i+j)).
            assign leaf[K] = {{(ACC_W-PP_W){pp[K][PP_W-1]}}, pp[K]} << (LIMB * (i + j));
        end
    end

    // Binary tree stored level by level: level l occupies node_q[O +: NPP>>l].
    for (genvar l = 1; l <= TREE_LVLS; l++) begin : g_lvl
        localparam int O  = NPP - ((2 * NPP) >> l);
        localparam int PO = NPP - ((2 * NPP) >> (l - 1));
        for (genvar n = 0; n < (NPP >> l); n++) begin : g_node
            if (l == 1) begin : g_leaf
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst)    node_q[n] <= '0;
                    else if (en) node_q[n] <= leaf[2*n] + leaf[2*n+1];
                end
            end else begin : g_int
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst)    node_q[O+n] <= '0;
                    else if (en) node_q[O+n] <= node_q[PO+2*n] + node_q[PO+2*n+1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DLY; k++) dly_q[k] <= '0;
            multout_q <= '0;
        end else if (en) begin
            dly_q[0] <= node_q[NPP-2][W_OUT-1:0];
            for (int k = 1; k < DLY; k++) dly_q[k] <= dly_q[k-1];
            multout_q <= dly_q[DLY-1];
        end
    end

    // Guard bits only absorb carries; the true product always fits in W_OUT bits.
    assign unused_guard = ^node_q[NPP-2][ACC_W-1:W_OUT];
    assign multout      = multout_q;
endmodule

// File: tb/tb_mult59x59_pipe.sv
`timescale 1ns/1ps
// Self-checking bench: scoreboard queue of golden products plus table-driven corner cases.
module tb_mult59x59_pipe;
    localparam logic [58:0] MAXP = 59'h3FFFFFFFFFFFFFF;
    localparam logic [58:0] MINN = 59'h400000000000000;
    localparam logic [58:0] NEG1 = 59'h7FFFFFFFFFFFFFF;
    localparam logic [58:0] C1   = 59'b011001010100110010000011110000011000011001000111100001;
    localparam logic [58:0] C2   = 59'b011010110011101010101101110110100101010110101010110010;

    typedef struct {
        logic [58:0]  r;
        logic [58:0]  s;
        logic [117:0] exp;
        string        name;
    } vec_t;

    logic         clk, rst, en;
    logic [58:0]  R, S;
    logic [117:0] multout;
    logic [117:0] sb [$];
    logic [117:0] exp_v;
    int           n_chk, n_fail;
    vec_t         tbl [5];

    mult59x59_pipe dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .R       (R),
        .S       (S),
        .multout (multout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [117:0] prod(input logic [58:0] a, input logic [58:0] b);
        logic signed [117:0] ae, be;
        ae = {{59{a[58]}}, a};
        be = {{59{b[58]}}, b};
        return ae * be;
    endfunction

    task automatic chk(input logic [117:0] act, input logic [117:0] exp, input string nm);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sb_clear();
        sb.delete();
        repeat (11) sb.push_back('0);
        exp_v = '0;
    endtask

    // Entered and left just after a falling edge.
    task automatic cyc(input logic e, input logic [58:0] r, input logic [58:0] s, input string nm);
        en = e;
        R  = r;
        S  = s;
        @(posedge clk);
        if (e) begin
            sb.push_back(prod(r, s));
            exp_v = sb.pop_front();
        end
        #1 chk(multout, exp_v, nm);
        @(negedge clk);
    endtask

    task automatic async_rst();
        #2 rst = 1'b0;
        #0.1 chk(multout, '0, "async_rst_now");
        #0.2 rst = 1'b1;
        sb_clear();
    endtask

    initial begin
        logic [58:0] r, s;
        logic [58:0] specials [5];
        n_chk  = 0;
        n_fail = 0;
        specials = '{59'd0, 59'd1, NEG1, MAXP, MINN};
        tbl[0] = '{59'd0, MAXP, 118'd0, "corner_zero"};
        tbl[1] = '{MAXP, MAXP, (118'(1) << 116) - (118'(1) << 59) + 118'd1, "corner_maxsq"};
        tbl[2] = '{MINN, MINN, 118'(1) << 116, "corner_minsq"};
        tbl[3] = '{NEG1, 59'd1, {118{1'b1}}, "corner_neg1"};
        tbl[4] = '{MINN, MAXP, 118'd0 - (118'(1) << 116) + (118'(1) << 58), "corner_minmax"};

        rst = 1'b0;
        en  = 1'b1;
        R   = 59'd5;
        S   = 59'd7;
        @(negedge clk);
        repeat (10) begin
            @(posedge clk);
            #1 chk(multout, '0, "reset_hold");
            @(negedge clk);
        end
        rst = 1'b1;
        sb_clear();
        repeat (12) cyc(1'b1, 59'd5, 59'd7, "reset_release");
        chk(multout, 118'd35, "reset_first_35");

        r = '0;
        s = MAXP;
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) async_rst();
            if ((i % 1000) == 500 || $urandom_range(0, 499) == 0)
                repeat (3) cyc(1'b0, 59'({$urandom(), $urandom()}), 59'({$urandom(), $urandom()}), "en_gap");
            cyc(1'b1, r, s, "stream");
            r = r + C1;
            s = s - C2;
        end

        foreach (tbl[k]) begin
            cyc(1'b1, tbl[k].r, tbl[k].s, "corner_in");
            repeat (11) cyc(1'b1, 59'd0, 59'd0, "corner_flush");
            chk(multout, tbl[k].exp, tbl[k].name);
        end

        for (int i = 0; i < 5000; i++) begin
            r = ($urandom_range(0, 9) == 0) ? specials[$urandom_range(0, 4)] : 59'({$urandom(), $urandom()});
            s = ($urandom_range(0, 9) == 0) ? specials[$urandom_range(0, 4)] : 59'({$urandom(), $urandom()});
            cyc(1'b1, r, s, "random");
        end
        repeat (12) cyc(1'b1, 59'd0, 59'd0, "drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mult59x59_pipe.md
Name: mult59x59_pipe

Overview:
- Fully pipelined signed 59x59-bit two's-complement multiplier producing the full 118-bit product.
- Accepts one operand pair per enabled clock; result appears a fixed 12 enabled clocks later.
- Intended as a DSP-slice-friendly replacement for a wide fabric multiply in arithmetic datapaths.
- Bit-exact against a 12-stage delayed behavioural multiply.

Parameters:
- None configurable. Widths are fixed.
- Localparams: W_IN = 59; W_OUT = 118; LIMB = 17; LATENCY = 12.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  clock enable for every pipeline register
- R  input  59  signed multiplicand, two's complement
- S  input  59  signed multiplier, two's complement
- multout  output  118  signed product R*S, registered

Behaviour:
- Reset:
  - rst=0 immediately clears every pipeline register, including multout, to 0, independent of clk and en.
  - Registers stay cleared while rst=0.
  - Deassertion is sampled on the next rising clk edge.
- Arithmetic:
  - multout = sign-extended R times sign-extended S, computed to 118 bits.
  - No overflow is possible, because 59+59 = 118.
  - Extremes: (-2^58)*(-2^58) = 2^116, with bit 117 = 0.
- Latency and enable:
  - Operands sampled at enabled edge k appear on multout after enabled edge k+11, i.e. 12 registered stages.
  - Stages count only enabled edges. With en=1 continuously, the product appears 12 clocks after sampling.
  - Throughput is one product per enabled cycle. There is no handshake and no stall beyond en.
  - en=0: all stages, including multout, hold their value. Gaps in en do not change the data ordering.
- After reset release with en=1: multout is 0 for the first 11 edges, then tracks the inputs with 12-cycle delay. Cleared stages propagate as 0*0 = 0.
- Reset mid-stream: all in-flight products are discarded. Output is 0 until the first post-reset operands emerge.
- Required structure (DSP mapping):
  - Split each operand into three unsigned 17-bit limbs (bits 16:0, 33:17, 50:34) and one signed 8-bit top limb (bits 58:51).
  - Form 16 limb partial products in 18x18 signed multipliers. Lower limbs are zero-extended to 18 bits; the top limb is sign-extended.
  - Accumulate with shifts of 17*(i+j) in a registered adder tree or cascade.
  - Balance delays so the total is exactly LATENCY stages.
  - Final stage is the 118-bit output register.
- Width rules: each partial product is 36 bits signed; intermediate sums carry at least 2 guard bits before truncation to 118.

Decomposition:
- Shared package mult59_pkg holds:
  - W_IN, W_OUT, LIMB, LATENCY localparams
  - limb-count constant (4)
  - typedef for a 36-bit signed partial product
- One sub-module, mult59_limb_mul:
  - registered 18x18 signed multiply with 2 pipeline stages, plus en and async active-low rst
  - instantiated 16 times
- Top level contains:
  - input registers
  - limb split
  - the shift/add accumulation tree
  - delay balancing
  - output register

Test Plan:
- Reset: hold rst=0 with R=5, S=7 for 10 cycles -> multout=0 throughout. Release -> multout=0 for 11 clocks, then 35 on the 12th.
- Corners (each pair applied for one cycle, en=1), each checked exactly 12 clocks later:
  - R=0, S=2^58-1 -> 0
  - R=S=2^58-1 -> 2^116-2^59+1
  - R=S=-2^58 -> 2^116
  - R=-1, S=1 -> all 118 bits set
  - R=-2^58, S=2^58-1 -> -(2^116)+2^58
- Streaming: start R=0, S=2^58-1. Each cycle add 0x19532 0F0 61 91E1 (54-bit constant 0b011001010100110010000011110000011000011001000111100001) to R and subtract 0b011010110011101010101101110110100101010110101010110010 from S, for 10000 cycles. multout must equal the 12-cycle-delayed golden signed product every cycle.
- Enable gaps: during streaming, drop en for 3 cycles at random points -> multout frozen during the gap; the output sequence equals the golden sequence with gaps removed.
- Async reset mid-stream: pulse rst=0 for 300 ps between edges -> multout=0 immediately. The next 11 enabled edges give 0, then the post-reset products.
- Random: 5000 random signed pairs, including 10% drawn from {0, ±1, 2^58-1, -2^58} -> exact match with 12-cycle latency.
